fifo_frame_writer: RTL and testbench
====================================

FIFO_FRAME_WRITER -- requirements
Module: fifo_frame_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the data word width in bits.
REQ-002 SHALL have parameter LENW, default 16, the width of the frame length and frame count counters.
REQ-003 SHALL have port clk_write, input, 1 bit, the write-side clock; all logic is posedge clk_write.
REQ-004 SHALL have port rst_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit, upstream word valid.
REQ-006 SHALL have port in_data, input, WIDTH bits, upstream data word.
REQ-007 SHALL have port in_last, input, 1 bit, marks the final word of a frame.
REQ-008 SHALL have port in_ready, output, 1 bit, upstream word accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port push_en, output, 1 bit, FIFO push strobe.
REQ-010 SHALL have port push_data, output, WIDTH bits, word to push into the FIFO.
REQ-011 SHALL have port full, input, 1 bit, FIFO full flag.
REQ-012 SHALL have port frame_done, output, 1 bit, one-cycle pulse when a frame's final word is pushed.
REQ-013 SHALL have port frame_len, output, LENW bits, word count of the last completed frame.
REQ-014 SHALL have port frame_count, output, LENW bits, number of completed frames.
REQ-015 SHALL have port busy, output, 1 bit, high while a frame is in progress or a word is pending.

Function
REQ-016 SHALL hold one output register (out_valid, out_data, out_last, out_trailer) plus one skid register, so upstream is never dropped or duplicated.
REQ-017 SHALL drive in_ready as a registered signal equal to NOT skid_valid AND NOT (state == TRAILER).
REQ-018 SHALL drive push_en = out_valid AND NOT full (combinational); push_data = out_data.
REQ-019 SHALL present a word accepted in cycle N on push_en no earlier than cycle N+1, with zero-stall throughput of one word per cycle.
REQ-020 SHALL, when full is high, hold the output register and fill the skid register; once the skid register is occupied, in_ready falls on the next cycle.
REQ-021 SHALL implement state machine IDLE -> DATA on the first accepted word; DATA -> IDLE on push of an out_last word; DATA -> TRAILER per REQ-031.
REQ-022 SHALL increment the frame word counter on each pushed data word, starting from 1, and saturate at 2^LENW-1.
REQ-023 SHALL, on the push of the final frame word, pulse frame_done for one cycle, load frame_len with the counter value, increment frame_count modulo 2^LENW, and clear the counter.
REQ-024 SHALL treat a single word with in_last high as a frame of length 1.
REQ-025 SHALL, when the skid register and the output register transfer while a new word arrives in the same cycle, preserve word order: output, then skid, then new.
REQ-026 SHALL, when full deasserts, resume pushing on that same cycle with no lost word.
REQ-027 SHALL keep busy high from the first accepted word until frame_done, and while any register holds a word.

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear state to IDLE, out_valid, skid_valid, push_en, frame_done, frame_len, frame_count, the word counter, and busy to 0, and set in_ready to 0.
REQ-029 SHALL set in_ready to 1 on the first clock after rst_n deasserts.
REQ-030 SHALL discard any partially written frame on reset mid-operation, with no frame_done and no trailer.

Configuration
REQ-031 SHALL, with macro FIFO_FRAME_TRAILER_EN defined, enter TRAILER after pushing the last data word, load the output register with the frame length (zero-extended or truncated to WIDTH), push it as one extra word subject to full, and only then pulse frame_done and return to IDLE.
REQ-032 SHALL, with FIFO_FRAME_TRAILER_EN defined, exclude the trailer word from frame_len and hold in_ready low while in TRAILER.
REQ-033 SHALL, without FIFO_FRAME_TRAILER_EN, have no TRAILER state and push no extra word.

Verification
REQ-034 SHALL verify: frame of 0x11,0x22,0x33 (last on 0x33) with full=0 -> push_en high for 3 consecutive cycles starting 1 cycle after the first accept, frame_done pulse, frame_len=3, frame_count=1.
REQ-035 SHALL verify: full=1 for 5 cycles during a 4-word frame -> in_ready low after 2 words are buffered, then all 4 words pushed in order, none duplicated.
REQ-036 SHALL verify: single word 0xA5 with in_last, with FIFO_FRAME_TRAILER_EN defined -> pushes 0xA5 then 0x01, frame_len=1.
REQ-037 SHALL verify: rst_n pulsed low after 2 of 5 words -> all outputs 0, frame_count=0, next frame counted from 1.
REQ-038 SHALL verify: 2^LENW frames with LENW=4 -> frame_count wraps to 0 after 16 frames.
REQ-039 SHALL verify: back-to-back frames with in_valid held high -> no bubble between frames when the trailer is disabled.

Source files
------------

// File: rtl/fifo_frame_writer.sv
// fifo_frame_writer: accepts framed words from a valid/ready upstream and
// pushes them into a FIFO guarded by a full flag. One output register plus
// one skid register absorb backpressure without dropping or repeating words.
// Reports the length of each completed frame and a running frame count.
// Optional feature: define FIFO_FRAME_TRAILER_EN to append one trailer word
// carrying the frame length after the last data word of every frame.
module fifo_frame_writer #(
    parameter int WIDTH = 8,
    parameter int LENW  = 16
) (
    input  logic             clk_write,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             push_en,
    output logic [WIDTH-1:0] push_data,
    input  logic             full,
    output logic             frame_done,
    output logic [LENW-1:0]  frame_len,
    output logic [LENW-1:0]  frame_count,
    output logic             busy
);

    localparam logic [LENW-1:0] CNT_MAX = '1;

`ifdef FIFO_FRAME_TRAILER_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        TRAILER = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;
`endif

    state_t r_state;
    state_t w_stateNext;

    // Output register: the word currently offered to the FIFO
    logic             r_outValid;
    logic [WIDTH-1:0] r_outData;
    logic             r_outLast;
    logic             r_outTrailer;

    // Skid register: catches the word accepted while the output is stalled
    logic             r_skidValid;
    logic [WIDTH-1:0] r_skidData;
    logic             r_skidLast;

    logic             r_inReady;
    logic [LENW-1:0]  r_wordCnt;
    logic [LENW-1:0]  r_frameLen;
    logic [LENW-1:0]  r_frameCount;
    logic             r_frameDone;

    // Next-state values for the datapath registers
    logic             w_outValidN;
    logic [WIDTH-1:0] w_outDataN;
    logic             w_outLastN;
    logic             w_outTrailerN;
    logic             w_skidValidN;
    logic [WIDTH-1:0] w_skidDataN;
    logic             w_skidLastN;
    logic             w_inReadyN;
    logic [LENW-1:0]  w_wordCntN;
    logic [LENW-1:0]  w_frameLenN;
    logic [LENW-1:0]  w_frameCountN;
    logic             w_frameDoneN;

    logic             w_push;
    logic             w_accept;
    logic             w_outFree;
    logic             w_pushData;
    logic             w_frameEnd;
    logic             w_pending;
    logic [LENW-1:0]  w_cntInc;
`ifdef FIFO_FRAME_TRAILER_EN
    logic             w_loadTrailer;
    logic [WIDTH-1:0] w_trailerWord;
`endif

    assign w_push     = r_outValid && !full;
    assign w_accept   = in_valid && r_inReady;
    assign w_outFree  = !r_outValid || w_push;
    assign w_pushData = w_push && !r_outTrailer;
    assign w_cntInc   = (r_wordCnt == CNT_MAX) ? r_wordCnt : r_wordCnt + 1'b1;
    assign w_pending  = w_outValidN || w_skidValidN;

`ifdef FIFO_FRAME_TRAILER_EN
    // With a trailer, the frame closes when the trailer word leaves
    assign w_loadTrailer = w_pushData && r_outLast;
    assign w_trailerWord = WIDTH'(w_cntInc);
    assign w_frameEnd    = w_push && r_outTrailer;
`else
    assign w_frameEnd    = w_pushData && r_outLast;
`endif

    assign in_ready    = r_inReady;
    assign push_en     = w_push;
    assign push_data   = r_outData;
    assign frame_done  = r_frameDone;
    assign frame_len   = r_frameLen;
    assign frame_count = r_frameCount;
    assign busy        = (r_state != IDLE) || r_outValid || r_skidValid;

    // Word movement: output drains first, skid refills it, new word goes behind
    always_comb begin
        w_outValidN   = r_outValid;
        w_outDataN    = r_outData;
        w_outLastN    = r_outLast;
        w_outTrailerN = r_outTrailer;
        w_skidValidN  = r_skidValid;
        w_skidDataN   = r_skidData;
        w_skidLastN   = r_skidLast;

        if (w_outFree) begin
            if (r_skidValid) begin
                w_outValidN   = 1'b1;
                w_outDataN    = r_skidData;
                w_outLastN    = r_skidLast;
                w_outTrailerN = 1'b0;
                w_skidValidN  = w_accept;
                if (w_accept) begin
                    w_skidDataN = in_data;
                    w_skidLastN = in_last;
                end
            end else if (w_accept) begin
                w_outValidN   = 1'b1;
                w_outDataN    = in_data;
                w_outLastN    = in_last;
                w_outTrailerN = 1'b0;
            end else begin
                w_outValidN   = 1'b0;
                w_outTrailerN = 1'b0;
            end
        end else if (w_accept) begin
            w_skidValidN = 1'b1;
            w_skidDataN  = in_data;
            w_skidLastN  = in_last;
        end

`ifdef FIFO_FRAME_TRAILER_EN
        // The trailer jumps ahead of any word already waiting in the skid
        if (w_loadTrailer) begin
            w_outValidN   = 1'b1;
            w_outDataN    = w_trailerWord;
            w_outLastN    = 1'b1;
            w_outTrailerN = 1'b1;
            w_skidValidN  = r_skidValid || w_accept;
            w_skidDataN   = w_accept ? in_data : r_skidData;
            w_skidLastN   = w_accept ? in_last : r_skidLast;
        end
`endif
    end

    // Frame bookkeeping: count pushed data words and publish at frame end
    always_comb begin
        w_wordCntN    = r_wordCnt;
        w_frameLenN   = r_frameLen;
        w_frameCountN = r_frameCount;
        w_frameDoneN  = 1'b0;

        if (w_pushData) begin
            w_wordCntN = w_cntInc;
        end

        if (w_frameEnd) begin
            w_frameDoneN  = 1'b1;
`ifdef FIFO_FRAME_TRAILER_EN
            w_frameLenN   = r_wordCnt;
`else
            w_frameLenN   = w_cntInc;
`endif
            w_frameCountN = r_frameCount + 1'b1;
            w_wordCntN    = '0;
        end
    end

    // Frame state: stays in DATA across frames while words are still queued
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_stateNext = DATA;
                end
            end
            DATA: begin
`ifdef FIFO_FRAME_TRAILER_EN
                if (w_loadTrailer) begin
                    w_stateNext = TRAILER;
                end
`else
                if (w_frameEnd) begin
                    w_stateNext = w_pending ? DATA : IDLE;
                end
`endif
            end
`ifdef FIFO_FRAME_TRAILER_EN
            TRAILER: begin
                if (w_frameEnd) begin
                    w_stateNext = w_pending ? DATA : IDLE;
                end
            end
`endif
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Upstream ready is registered and mirrors the next skid/state occupancy
    always_comb begin
        w_inReadyN = !w_skidValidN;
`ifdef FIFO_FRAME_TRAILER_EN
        if (w_stateNext == TRAILER) begin
            w_inReadyN = 1'b0;
        end
`endif
    end

    // State register
    always_ff @(posedge clk_write or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Datapath and counter registers; reset drops any partial frame
    always_ff @(posedge clk_write or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid   <= 1'b0;
            r_outData    <= '0;
            r_outLast    <= 1'b0;
            r_outTrailer <= 1'b0;
            r_skidValid  <= 1'b0;
            r_skidData   <= '0;
            r_skidLast   <= 1'b0;
            r_inReady    <= 1'b0;
            r_wordCnt    <= '0;
            r_frameLen   <= '0;
            r_frameCount <= '0;
            r_frameDone  <= 1'b0;
        end else begin
            r_outValid   <= w_outValidN;
            r_outData    <= w_outDataN;
            r_outLast    <= w_outLastN;
            r_outTrailer <= w_outTrailerN;
            r_skidValid  <= w_skidValidN;
            r_skidData   <= w_skidDataN;
            r_skidLast   <= w_skidLastN;
            r_inReady    <= w_inReadyN;
            r_wordCnt    <= w_wordCntN;
            r_frameLen   <= w_frameLenN;
            r_frameCount <= w_frameCountN;
            r_frameDone  <= w_frameDoneN;
        end
    end

endmodule

// File: tb/tb_fifo_frame_writer.sv
// Testbench for fifo_frame_writer (LENW=4 so counter wrap and saturation are
// reachable). Works with or without FIFO_FRAME_TRAILER_EN defined.
module tb_fifo_frame_writer;

    localparam int WIDTH   = 8;
    localparam int LENW    = 4;
    localparam int LEN_MAX = 15;
`ifdef FIFO_FRAME_TRAILER_EN
    localparam int B2B_PUSHES = 7;
`else
    localparam int B2B_PUSHES = 5;
`endif

    logic             clkWrite = 1'b0;
    logic             rstN;
    logic             inValid;
    logic [WIDTH-1:0] inData;
    logic             inLast;
    logic             inReady;
    logic             pushEn;
    logic [WIDTH-1:0] pushData;
    logic             full;
    logic             frameDone;
    logic [LENW-1:0]  frameLen;
    logic [LENW-1:0]  frameCount;
    logic             busy;

    int errors = 0;
    int checks = 0;

    fifo_frame_writer #(.WIDTH(WIDTH), .LENW(LENW)) dut (
        .clk_write  (clkWrite),
        .rst_n      (rstN),
        .in_valid   (inValid),
        .in_data    (inData),
        .in_last    (inLast),
        .in_ready   (inReady),
        .push_en    (pushEn),
        .push_data  (pushData),
        .full       (full),
        .frame_done (frameDone),
        .frame_len  (frameLen),
        .frame_count(frameCount),
        .busy       (busy)
    );

    always #5 clkWrite = ~clkWrite;

    // Reference model: the expected FIFO word stream and per-frame lengths
    typedef struct {
        logic [WIDTH-1:0] data;
        bit               isFinal;
    } exp_t;

    exp_t expQ[$];
    int   lenQ[$];
    int   frameWords    = 0;
    int   expCount      = 0;
    bit   pendDone      = 1'b0;
    int   pendLen       = 0;
    int   pushedInFrame = 0;
    int   cycle         = 0;
    int   pushCnt       = 0;
    int   firstPush     = 0;
    int   lastPush      = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard: compare every push and frame report against the model
    always @(negedge clkWrite) begin
        exp_t e;
        cycle++;
        if (!rstN) begin
            expQ.delete();
            lenQ.delete();
            frameWords    = 0;
            expCount      = 0;
            pendDone      = 1'b0;
            pushedInFrame = 0;
        end else begin
            checkOutput("frame_done", frameDone, pendDone);
            if (pendDone) checkOutput("frame_len_at_done", frameLen, pendLen);
            checkOutput("frame_count", frameCount, expCount);
            checkOutput("busy", busy, (expQ.size() != 0 || pushedInFrame > 0));
            checkOutput("push_while_full", pushEn & full, 1'b0);
            pendDone = 1'b0;
            if (pushEn) begin
                pushCnt++;
                if (pushCnt == 1) firstPush = cycle;
                lastPush = cycle;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_push: got data 0x%0h, expected no push", pushData);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("push_data", pushData, e.data);
                    if (e.isFinal) begin
                        pendDone      = 1'b1;
                        pendLen       = lenQ.pop_front();
                        expCount      = (expCount + 1) % (1 << LENW);
                        pushedInFrame = 0;
                    end else begin
                        pushedInFrame++;
                    end
                end
            end
            if (inValid && inReady) begin
                if (frameWords < LEN_MAX) frameWords++;
`ifdef FIFO_FRAME_TRAILER_EN
                e.data = inData;
                e.isFinal = 1'b0;
                expQ.push_back(e);
                if (inLast) begin
                    e.data = WIDTH'(frameWords);
                    e.isFinal = 1'b1;
                    expQ.push_back(e);
                end
`else
                e.data = inData;
                e.isFinal = inLast;
                expQ.push_back(e);
`endif
                if (inLast) begin
                    lenQ.push_back(frameWords);
                    frameWords = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clkWrite);
        #1;
    endtask

    // Offer one word and hold it until the handshake completes
    task automatic applyStimulus(input logic [WIDTH-1:0] d, input bit l, input int fullPct);
        inValid = 1'b1;
        inData  = d;
        inLast  = l;
        for (int n = 0; n < 300; n++) begin
            @(negedge clkWrite);
            if (inReady) begin
                tick();
                inValid = 1'b0;
                full    = ($urandom_range(99) < fullPct);
                return;
            end
            tick();
            full = ($urandom_range(99) < fullPct);
        end
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout: got in_ready=0 for 300 cycles, expected 1");
        inValid = 1'b0;
    endtask

    task automatic idle(input int n, input int fullPct);
        inValid = 1'b0;
        repeat (n) begin
            tick();
            full = ($urandom_range(99) < fullPct);
        end
    endtask

    task automatic waitDrain();
        full = 1'b0;
        for (int n = 0; n < 300; n++) begin
            tick();
            if (expQ.size() == 0 && !pendDone) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL drain_timeout: got %0d words outstanding, expected 0", expQ.size());
    endtask

    task automatic doReset();
        rstN    = 1'b0;
        inValid = 1'b0;
        full    = 1'b0;
        tick();
        tick();
        rstN = 1'b1;
        tick();
    endtask

    task automatic sendRandomFrame(input int fullPct);
        int len;
        len = $urandom_range(1, 6);
        for (int i = 0; i < len; i++) begin
            applyStimulus(WIDTH'($urandom_range(255)), (i == len - 1), fullPct);
        end
        idle($urandom_range(0, 3), fullPct);
    endtask

    typedef struct {
        bit               valid;
        logic [WIDTH-1:0] data;
        bit               last;
        bit               fullIn;
        bit               eRdy;
        bit               ePush;
        logic [WIDTH-1:0] eData;
        bit               eDone;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Three-word frame 0x11,0x22,0x33 straight after reset, cycle by cycle
        vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[2] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0};
        vecs[3] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0};
`ifdef FIFO_FRAME_TRAILER_EN
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
`else
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
`endif
        vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};

        rstN    = 1'b0;
        inValid = 1'b0;
        inData  = '0;
        inLast  = 1'b0;
        full    = 1'b0;
        repeat (2) @(posedge clkWrite);
        @(negedge clkWrite);
        checkOutput("rst_in_ready", inReady, 1'b0);
        checkOutput("rst_push_en", pushEn, 1'b0);
        checkOutput("rst_frame_done", frameDone, 1'b0);
        checkOutput("rst_frame_len", frameLen, 0);
        checkOutput("rst_frame_count", frameCount, 0);
        checkOutput("rst_busy", busy, 1'b0);
        @(posedge clkWrite);
        #1;
        rstN = 1'b1;

        for (int i = 0; i < 8; i++) begin
            tick();
            inValid = vecs[i].valid;
            inData  = vecs[i].data;
            inLast  = vecs[i].last;
            full    = vecs[i].fullIn;
            @(negedge clkWrite);
            checkOutput($sformatf("vec%0d_in_ready", i), inReady, vecs[i].eRdy);
            checkOutput($sformatf("vec%0d_push_en", i), pushEn, vecs[i].ePush);
            if (vecs[i].ePush) checkOutput($sformatf("vec%0d_push_data", i), pushData, vecs[i].eData);
            checkOutput($sformatf("vec%0d_frame_done", i), frameDone, vecs[i].eDone);
        end
        checkOutput("vec_frame_len", frameLen, 3);
        checkOutput("vec_frame_count", frameCount, 1);

        // Backpressure: full held for five cycles while a 4-word frame arrives
        tick();
        full = 1'b1; inValid = 1'b1; inData = 8'h41; inLast = 1'b0;
        @(negedge clkWrite);
        checkOutput("stall_rdy_w0", inReady, 1'b1);
        tick();
        inData = 8'h42;
        @(negedge clkWrite);
        checkOutput("stall_rdy_w1", inReady, 1'b1);
        tick();
        inData = 8'h43;
        @(negedge clkWrite);
        checkOutput("stall_rdy_low", inReady, 1'b0);
        checkOutput("stall_no_push", pushEn, 1'b0);
        tick();
        @(negedge clkWrite);
        checkOutput("stall_rdy_low2", inReady, 1'b0);
        tick();
        @(negedge clkWrite);
        checkOutput("stall_rdy_low3", inReady, 1'b0);
        tick();
        full = 1'b0;
        @(negedge clkWrite);
        checkOutput("resume_push_en", pushEn, 1'b1);
        checkOutput("resume_push_data", pushData, 8'h41);
        tick();
        applyStimulus(8'h43, 1'b0, 0);
        applyStimulus(8'h44, 1'b1, 0);
        waitDrain();
        checkOutput("stall_frame_len", frameLen, 4);
        checkOutput("stall_frame_count", frameCount, 2);

        // Single-word frame
        applyStimulus(8'hA5, 1'b1, 0);
        waitDrain();
        checkOutput("single_frame_len", frameLen, 1);
        checkOutput("single_frame_count", frameCount, 3);

        // 17-word frame saturates the length counter
        for (int i = 0; i < 17; i++) begin
            applyStimulus(WIDTH'(i + 8'h80), (i == 16), 0);
        end
        waitDrain();
        checkOutput("sat_frame_len", frameLen, LEN_MAX);
        checkOutput("sat_frame_count", frameCount, 4);

        // Back-to-back frames with valid held high
        pushCnt = 0;
        applyStimulus(8'hB0, 1'b0, 0);
        applyStimulus(8'hB1, 1'b1, 0);
        applyStimulus(8'hC0, 1'b0, 0);
        applyStimulus(8'hC1, 1'b0, 0);
        applyStimulus(8'hC2, 1'b1, 0);
        waitDrain();
        checkOutput("b2b_push_count", pushCnt, B2B_PUSHES);
        checkOutput("b2b_no_bubble", lastPush - firstPush + 1, pushCnt);
        checkOutput("b2b_frame_count", frameCount, 6);

        // Reset in the middle of a frame discards it
        full = 1'b1;
        applyStimulus(8'h61, 1'b0, 100);
        applyStimulus(8'h62, 1'b0, 100);
        rstN    = 1'b0;
        inValid = 1'b0;
        @(negedge clkWrite);
        checkOutput("midrst_in_ready", inReady, 1'b0);
        checkOutput("midrst_push_en", pushEn, 1'b0);
        checkOutput("midrst_frame_done", frameDone, 1'b0);
        checkOutput("midrst_frame_len", frameLen, 0);
        checkOutput("midrst_frame_count", frameCount, 0);
        checkOutput("midrst_busy", busy, 1'b0);
        tick();
        rstN = 1'b1;
        full = 1'b0;
        tick();
        @(negedge clkWrite);
        checkOutput("ready_after_reset", inReady, 1'b1);
        tick();
        applyStimulus(8'h71, 1'b0, 0);
        applyStimulus(8'h72, 1'b0, 0);
        applyStimulus(8'h73, 1'b1, 0);
        waitDrain();
        checkOutput("postrst_frame_len", frameLen, 3);
        checkOutput("postrst_frame_count", frameCount, 1);

        // Sixteen random frames wrap the 4-bit frame counter back to zero
        doReset();
        for (int f = 0; f < 16; f++) sendRandomFrame(30);
        waitDrain();
        checkOutput("wrap_frame_count", frameCount, 0);

        // Longer random run with heavy backpressure
        for (int f = 0; f < 40; f++) sendRandomFrame(45);
        waitDrain();
        checkOutput("random_frame_count", frameCount, 8);
        checkOutput("random_idle_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
